// File: rtl/dl_pkg.sv
// Shared definitions for the per-process dataflow deadlock detector.
//   - FSM state encoding (IDLE / WAIT / DEADLOCK)
//   - calc_idw: width of a process index for a given process count
//   - lowest_set_idx: index of the least-significant set bit of a vector
package dl_pkg;

  localparam logic [1:0] StIdle     = 2'b00;
  localparam logic [1:0] StWait     = 2'b01;
  localparam logic [1:0] StDeadlock = 2'b10;

  // Never returns 0 so index fields always have at least one bit.
  function automatic int unsigned calc_idw(input int unsigned num);
    return (num <= 1) ? 1 : $clog2(num);
  endfunction

  // Returns 0 when no bit is set; callers qualify with |vec.
  function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dl_stall_filter.sv
// Stall filter: counts consecutive blocked cycles and flags when the
// threshold is reached.
//   dl_clock      in   clock
//   dl_reset      in   asynchronous active-low reset
//   proc_blocked  in   process stalled this cycle
//   stall_ok      out  blocked and STALL_THRESH-1 prior blocked cycles seen
module dl_stall_filter
  import dl_pkg::*;
#(
  parameter int unsigned STALL_THRESH = 16
) (
  input  logic dl_clock,
  input  logic dl_reset,
  input  logic proc_blocked,
  output logic stall_ok
);

  localparam int unsigned CW = (STALL_THRESH > 1) ? $clog2(STALL_THRESH) : 1;
  localparam logic [CW-1:0] CntMax = CW'(STALL_THRESH - 1);

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  // Saturates at CntMax so a long stall never wraps back below threshold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!proc_blocked) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CntMax) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_ok = proc_blocked && (stall_cnt_q == CntMax);

endmodule

// File: rtl/dl_proc_detect_unit.sv
// Per-process deadlock detector. Filters sustained stalls, exchanges
// dependency vectors with peers on blocking channels, flags a closed
// dependency cycle through this process, and relays the report token.
//   dl_clock / dl_reset        clock, async active-low reset
//   proc_blocked               process stalled this cycle
//   chan_block_vec             per-channel blocking flags
//   chan_peer_id               static peer index per channel (IDW each)
//   chan_dep_in_vld/_data      peer dependency vectors (PROC_NUM each)
//   dl_report_in               report unit in report mode
//   origin                     report unit's origin pulse
//   token_clear                report unit's cycle-complete pulse
//   token_in                   token arriving from any peer
//   dl_out                     this process's deadlock flag / token indicator
//   dep_out_vld / dep_out_data dependency vector to peers
//   token_out_vec              one-hot token to next peer
module dl_proc_detect_unit
  import dl_pkg::*;
#(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned PROC_ID      = 0,
  parameter int unsigned CHAN_NUM     = 2,
  parameter int unsigned STALL_THRESH = 16,
  parameter int unsigned IDW          = calc_idw(PROC_NUM)
) (
  input  logic                         dl_clock,
  input  logic                         dl_reset,
  input  logic                         proc_blocked,
  input  logic [CHAN_NUM-1:0]          chan_block_vec,
  input  logic [CHAN_NUM*IDW-1:0]      chan_peer_id,
  input  logic [CHAN_NUM-1:0]          chan_dep_in_vld,
  input  logic [CHAN_NUM*PROC_NUM-1:0] chan_dep_in_data,
  input  logic                         dl_report_in,
  input  logic [PROC_NUM-1:0]          origin,
  input  logic                         token_clear,
  input  logic                         token_in,
  output logic                         dl_out,
  output logic                         dep_out_vld,
  output logic [PROC_NUM-1:0]          dep_out_data,
  output logic [PROC_NUM-1:0]          token_out_vec
);

  localparam logic [PROC_NUM-1:0] SelfOneHot = PROC_NUM'(1) << PROC_ID;

  logic [1:0]          state_q, state_d;
  logic [PROC_NUM-1:0] dep_reg_q, dep_reg_d;
  logic                origin_flag_q, origin_flag_d;
  logic                token_hold_q, token_hold_d;
  logic [PROC_NUM-1:0] token_out_q, token_out_d;
  logic                stall_ok;

  logic [PROC_NUM-1:0] merge;
  logic [CHAN_NUM-1:0] fwd_vec;
  logic [31:0]         fwd_vec_ext;
  int unsigned         fwd_idx;
  logic [IDW-1:0]      peer_id;
  logic [PROC_NUM-1:0] peer_onehot;
  logic                has_peer;

  dl_stall_filter #(
    .STALL_THRESH(STALL_THRESH)
  ) u_stall_filter (
    .dl_clock    (dl_clock),
    .dl_reset    (dl_reset),
    .proc_blocked(proc_blocked),
    .stall_ok    (stall_ok)
  );

  // Merge term and forward candidates: a channel counts only when it blocks
  // us and its peer currently publishes a valid vector.
  always_comb begin
    merge   = '0;
    fwd_vec = '0;
    for (int c = 0; c < int'(CHAN_NUM); c++) begin
      if (chan_block_vec[c] && chan_dep_in_vld[c]) begin
        merge      = merge | chan_dep_in_data[c*PROC_NUM +: PROC_NUM];
        fwd_vec[c] = chan_dep_in_data[c*PROC_NUM + PROC_ID];
      end
    end
  end

  // The next hop is the lowest channel whose peer already depends on us.
  always_comb begin
    fwd_vec_ext                = '0;
    fwd_vec_ext[CHAN_NUM-1:0]  = fwd_vec;
    fwd_idx                    = lowest_set_idx(fwd_vec_ext);
    has_peer                   = |fwd_vec;
    peer_id                    = chan_peer_id[fwd_idx*IDW +: IDW];
    peer_onehot                = '0;
    peer_onehot[peer_id]       = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    dep_reg_d     = dep_reg_q;
    origin_flag_d = origin_flag_q;
    token_hold_d  = 1'b0;
    token_out_d   = '0;
    case (state_q)
      StIdle: begin
        if (stall_ok) begin
          state_d   = StWait;
          dep_reg_d = SelfOneHot;
        end
      end
      StWait: begin
        if (!proc_blocked) begin
          state_d   = StIdle;
          dep_reg_d = '0;
        end else begin
          dep_reg_d = dep_reg_q | merge;
          if (merge[PROC_ID]) state_d = StDeadlock;
        end
      end
      StDeadlock: begin
        if (!proc_blocked) begin
          // Leaving aborts any token activity; hold/out already default to 0.
          state_d       = StIdle;
          dep_reg_d     = '0;
          origin_flag_d = 1'b0;
        end else begin
          dep_reg_d = dep_reg_q | merge;
          if (token_clear) begin
            origin_flag_d = 1'b0;
          end else begin
            if (origin[PROC_ID]) origin_flag_d = 1'b1;
            token_hold_d = token_in;
            // The origin closes the cycle when the token returns: no forward.
            if (has_peer && (origin[PROC_ID] || (token_in && !origin_flag_q))) begin
              token_out_d = peer_onehot;
            end
          end
        end
      end
      default: begin
        state_d       = StIdle;
        dep_reg_d     = '0;
        origin_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      state_q       <= StIdle;
      dep_reg_q     <= '0;
      origin_flag_q <= 1'b0;
      token_hold_q  <= 1'b0;
      token_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      dep_reg_q     <= dep_reg_d;
      origin_flag_q <= origin_flag_d;
      token_hold_q  <= token_hold_d;
      token_out_q   <= token_out_d;
    end
  end

  assign dep_out_vld   = (state_q != StIdle);
  assign dep_out_data  = dep_out_vld ? dep_reg_q : '0;
  assign dl_out        = (state_q == StDeadlock) && (!dl_report_in || token_hold_q);
  assign token_out_vec = token_out_q;

endmodule
